// File: rtl/mouse_pos_pkg.sv
// Shared types and range helpers for the mouse cursor tracker.
// MOUSE_POS_WRAP_EN (see mouse_pos_tracker) selects wrap_range over clamp_range at commit.
package mouse_pos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_COMMIT
  } state_e;

  // Saturate v into [0, n-1].
  function automatic int clamp_range(input int v, input int n);
    if (v < 0) return 0;
    if (v >= n) return n - 1;
    return v;
  endfunction

  // Single-step modular correction; callers guarantee |step| < n.
  function automatic int wrap_range(input int v, input int n);
    if (v < 0) return v + n;
    if (v >= n) return v - n;
    return v;
  endfunction

endpackage

// File: rtl/mouse_btn_events.sv
// Per-button level tracking with sticky press/release events, per-bit acknowledge and irq.
module mouse_btn_events #(
  parameter int unsigned BTN_N = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             evt_en_i,
  input  logic [BTN_N-1:0] btn_i,
  input  logic [BTN_N-1:0] ack_i,
  output logic [BTN_N-1:0] btn_level_o,
  output logic [BTN_N-1:0] btn_press_o,
  output logic [BTN_N-1:0] btn_rel_o,
  output logic             irq_o
);

  logic [BTN_N-1:0] level_q, level_d;
  logic [BTN_N-1:0] press_q, press_d;
  logic [BTN_N-1:0] rel_q, rel_d;
  logic [BTN_N-1:0] rise, fall;

  always_comb begin
    rise    = '0;
    fall    = '0;
    level_d = level_q;
    if (evt_en_i) begin
      rise    = btn_i & ~level_q;
      fall    = ~btn_i & level_q;
      level_d = btn_i;
    end
    // New edges are OR-ed in after the ack mask so a same-cycle event survives.
    press_d = (press_q & ~ack_i) | rise;
    rel_d   = (rel_q & ~ack_i) | fall;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level_o = level_q;
  assign btn_press_o = press_q;
  assign btn_rel_o   = rel_q;
  assign irq_o       = (|press_q) | (|rel_q);

endmodule

// File: rtl/mouse_pos_tracker.sv
// Integrates PS/2 movement packets into an absolute cursor position with button events.
// Define MOUSE_POS_WRAP_EN to wrap the cursor at screen edges instead of clamping.
module mouse_pos_tracker
  import mouse_pos_pkg::*;
#(
  parameter int unsigned WIDTH       = 1280,
  parameter int unsigned HEIGHT      = 1080,
  parameter int unsigned DELTA_W     = 9,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned BTN_N       = 3,
  parameter int unsigned DROP_CNT_W  = 8,
  localparam int unsigned XW         = $clog2(WIDTH),
  localparam int unsigned YW         = $clog2(HEIGHT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [DELTA_W-1:0]    dx_i,
  input  logic [DELTA_W-1:0]    dy_i,
  input  logic [BTN_N-1:0]      btn_i,
  input  logic                  set_pos_i,
  input  logic [XW-1:0]         set_x_i,
  input  logic [YW-1:0]         set_y_i,
  input  logic [BTN_N-1:0]      ack_i,
  output logic [XW-1:0]         x_pos_o,
  output logic [YW-1:0]         y_pos_o,
  output logic                  pos_upd_o,
  output logic [BTN_N-1:0]      btn_level_o,
  output logic [BTN_N-1:0]      btn_press_o,
  output logic [BTN_N-1:0]      btn_rel_o,
  output logic                  irq_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned SW = ((XW > YW) ? XW : YW) + DELTA_W + SCALE_SHIFT + 2;

  if (SW > 32) begin : g_sw_chk
    $error("mouse_pos_tracker: sum width exceeds 32 bits");
  end

`ifdef MOUSE_POS_WRAP_EN
  localparam longint unsigned MAX_STEP = longint'(1) << (DELTA_W - 1 + SCALE_SHIFT);
  if (MAX_STEP >= WIDTH || MAX_STEP >= HEIGHT) begin : g_wrap_chk
    $error("mouse_pos_tracker: scaled delta range too large for single-step wrap");
  end
`endif

  typedef struct packed {
    logic signed [DELTA_W-1:0] dx;
    logic signed [DELTA_W-1:0] dy;
  } delta_t;

  state_e                 state_q, state_d;
  delta_t                 delta_q, delta_d;
  logic signed [SW-1:0]   sx_q, sx_d, sy_q, sy_d;
  logic signed [SW-1:0]   x_s, y_s, dx_s, dy_s;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   pos_upd_q, pos_upd_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   accept, dropped;

  // A packet offered alongside set_pos_i is refused and counted as a drop.
  assign accept  = pkt_valid_i & pkt_ready_o & ~set_pos_i;
  assign dropped = pkt_valid_i & (~pkt_ready_o | set_pos_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SUM;
      ST_SUM:    state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (set_pos_i) state_d = ST_IDLE;
  end

  always_comb begin
    pkt_ready_o = (state_q == ST_IDLE);
  end

  assign x_s  = SW'(x_q);
  assign y_s  = SW'(y_q);
  assign dx_s = SW'(delta_q.dx) <<< SCALE_SHIFT;
  assign dy_s = SW'(delta_q.dy) <<< SCALE_SHIFT;

  always_comb begin
    delta_d   = delta_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    x_d       = x_q;
    y_d       = y_q;
    pos_upd_d = 1'b0;
    drop_d    = drop_q;

    if (accept) begin
      delta_d.dx = dx_i;
      delta_d.dy = dy_i;
    end

    if (state_q == ST_SUM) begin
      sx_d = x_s + dx_s;
      sy_d = y_s - dy_s;
    end

    if (state_q == ST_COMMIT) begin
`ifdef MOUSE_POS_WRAP_EN
      x_d = XW'(wrap_range(int'(sx_q), int'(WIDTH)));
      y_d = YW'(wrap_range(int'(sy_q), int'(HEIGHT)));
`else
      x_d = XW'(clamp_range(int'(sx_q), int'(WIDTH)));
      y_d = YW'(clamp_range(int'(sy_q), int'(HEIGHT)));
`endif
      pos_upd_d = 1'b1;
    end

    if (set_pos_i) begin
      x_d       = XW'(clamp_range(int'(set_x_i), int'(WIDTH)));
      y_d       = YW'(clamp_range(int'(set_y_i), int'(HEIGHT)));
      pos_upd_d = 1'b1;
    end

    if (dropped && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      delta_q   <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      x_q       <= XW'(WIDTH / 2);
      y_q       <= YW'(HEIGHT / 2);
      pos_upd_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      delta_q   <= delta_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pos_upd_q <= pos_upd_d;
      drop_q    <= drop_d;
    end
  end

  assign x_pos_o    = x_q;
  assign y_pos_o    = y_q;
  assign pos_upd_o  = pos_upd_q;
  assign drop_cnt_o = drop_q;

  mouse_btn_events #(
    .BTN_N(BTN_N)
  ) u_btn_events (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .evt_en_i    (accept),
    .btn_i       (btn_i),
    .ack_i       (ack_i),
    .btn_level_o (btn_level_o),
    .btn_press_o (btn_press_o),
    .btn_rel_o   (btn_rel_o),
    .irq_o       (irq_o)
  );

endmodule
